v_tile_out_router: RTL and testbench

// - Downstream stage of v_tile: captures each adder result vector plus its dest_info on adder_ack,

---
 rtl/v_tile_out_router.sv | 160 ++++++++++++++++
 tb/tb_v_tile_out_router.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v_tile_out_router.sv
// Output router for v_tile: buffers adder result vectors in a small FIFO and multicasts each
// one to the N/E/S/W neighbours. Optional stats counters are enabled by defining ROUTER_STATS_EN.
module v_tile_out_router #(
    parameter int width      = 16,
    parameter int num_inputs = 4,
    parameter int depth      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [width*num_inputs-1:0] adder_outputs,
    input  logic [3:0]                  dest_info,
    input  logic                        adder_ack,
    output logic                        cap_rdy,
    output logic [width*num_inputs-1:0] out_data,
    output logic [3:0]                  out_en,
    input  logic [3:0]                  out_rdy,
    input  logic [3:0]                  out_ack,
    output logic                        ovf
`ifdef ROUTER_STATS_EN
    ,
    output logic [15:0]                 sent_cnt,
    output logic [15:0]                 drop_cnt
`endif
);

    localparam int VW = width * num_inputs;
    localparam int AW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic [VW-1:0] data_mem [depth];
    logic [3:0]    dest_mem [depth];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    state_t        state_reg;
    state_t        state_next;
    logic [3:0]    pend_reg;
    logic [3:0]    pend_next;
    logic [3:0]    en_reg;
    logic [3:0]    en_next;
    logic [3:0]    retire;
    logic          ovf_reg;
    logic          push;
    logic          pop;
    logic          empty;
    logic [3:0]    head_dest;

    assign empty     = (count_reg == '0);
    assign cap_rdy   = (count_reg != CW'(depth));
    assign push      = adder_ack && cap_rdy;
    assign head_dest = dest_mem[rd_ptr_reg];
    assign out_data  = empty ? '0 : data_mem[rd_ptr_reg];
    assign out_en    = en_reg;
    assign ovf       = ovf_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= adder_outputs;
            dest_mem[wr_ptr_reg] <= dest_info;
        end
    end

    // An enable only rises on a sampled rdy and then holds until that direction acks.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dir
            assign retire[gi]  = en_reg[gi] && out_ack[gi];
            assign en_next[gi] = (state_reg == SEND) &&
                                 (en_reg[gi] ? !out_ack[gi] : (pend_reg[gi] && out_rdy[gi]));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        pend_next  = pend_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    if (head_dest == 4'b0000) begin
                        pop = 1'b1;
                    end else begin
                        pend_next  = head_dest;
                        state_next = SEND;
                    end
                end
            end
            SEND: begin
                pend_next = pend_reg & ~retire;
                if (pend_next == 4'b0000) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            state_reg  <= IDLE;
            pend_reg   <= 4'b0000;
            en_reg     <= 4'b0000;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            en_reg    <= en_next;
            count_reg <= count_reg + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (adder_ack && !cap_rdy) begin
                ovf_reg <= 1'b1;
            end
        end
    end

`ifdef ROUTER_STATS_EN
    logic [15:0] sent_cnt_reg;
    logic [15:0] drop_cnt_reg;
    logic        sent_inc;
    logic        ovf_drop;
    logic        discard;
    logic [16:0] drop_sum;

    assign sent_inc = pop && (state_reg == SEND);
    assign discard  = pop && (state_reg == IDLE);
    assign ovf_drop = adder_ack && !cap_rdy;
    // An overflow drop and a discard can land in the same cycle, so add both before saturating.
    assign drop_sum = {1'b0, drop_cnt_reg} + {16'b0, ovf_drop} + {16'b0, discard};
    assign sent_cnt = sent_cnt_reg;
    assign drop_cnt = drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sent_cnt_reg <= 16'h0000;
            drop_cnt_reg <= 16'h0000;
        end else begin
            if (sent_inc && (sent_cnt_reg != 16'hFFFF)) begin
                sent_cnt_reg <= sent_cnt_reg + 16'h0001;
            end
            drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_v_tile_out_router.sv
// Bench for v_tile_out_router: queue-based reference model compared every cycle, neighbour
// responders with per-direction ack delay, and directed scenarios with literal expectations.
module tb_v_tile_out_router;

    localparam int VW = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [VW-1:0] adder_outputs = '0;
    logic [3:0]    dest_info = 4'b0000;
    logic          adder_ack = 1'b0;
    logic          cap_rdy;
    logic [VW-1:0] out_data;
    logic [3:0]    out_en;
    logic [3:0]    out_rdy = 4'b0000;
    logic [3:0]    out_ack;
    logic          ovf;
`ifdef ROUTER_STATS_EN
    logic [15:0]   sent_cnt;
    logic [15:0]   drop_cnt;
`endif

    v_tile_out_router dut (
        .clk(clk),
        .reset(reset),
        .adder_outputs(adder_outputs),
        .dest_info(dest_info),
        .adder_ack(adder_ack),
        .cap_rdy(cap_rdy),
        .out_data(out_data),
        .out_en(out_en),
        .out_rdy(out_rdy),
        .out_ack(out_ack),
        .ovf(ovf)
`ifdef ROUTER_STATS_EN
        ,
        .sent_cnt(sent_cnt),
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [VW-1:0] mkvec(input int k);
        return {16'(k), 16'(k + 1), 16'(k + 2), 16'(k + 3)};
    endfunction

    // Neighbour responders: ack arrives dly[d] cycles after en is first seen.
    logic [3:0] resp_ack = 4'b0000;
    logic [3:0] spur_ack = 4'b0000;
    int dly[4] = '{0, 0, 0, 0};
    int age[4] = '{0, 0, 0, 0};
    assign out_ack = resp_ack | spur_ack;

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 4; d++) begin
            if (!out_en[d]) begin
                resp_ack[d] = 1'b0;
                age[d] = 0;
            end else if (!resp_ack[d]) begin
                if (age[d] >= dly[d]) resp_ack[d] = 1'b1;
                else age[d]++;
            end
        end
    end

    // Delivery log observed on the neighbour ports.
    typedef struct {
        int            c;
        int            dir;
        logic [VW-1:0] data;
    } dlv_t;
    dlv_t dlog[$];

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            for (int d = 0; d < 4; d++) begin
                if (out_en[d] && out_ack[d]) begin
                    dlog.push_back('{cyc, d, out_data});
                    $display("deliver cycle=%0d dir=%0d data=%h", cyc, d, out_data);
                end
            end
        end
    end

    // Reference model: FIFO as a queue, one outstanding vector being multicast.
    typedef struct packed {
        logic [VW-1:0] data;
        logic [3:0]    dest;
    } ent_t;
    ent_t       m_q[$];
    bit         m_busy = 1'b0;
    logic [3:0] m_pend = 4'b0000;
    logic [3:0] m_en = 4'b0000;
    bit         m_ovf = 1'b0;
    int         m_sent = 0;
    int         m_drop = 0;

    always @(posedge clk) begin
        bit room;
        logic [3:0] acked;
        logic [3:0] grant;
        ent_t gone;
        if (reset) begin
            m_q.delete();
            m_busy = 1'b0;
            m_pend = 4'b0000;
            m_en = 4'b0000;
            m_ovf = 1'b0;
            m_sent = 0;
            m_drop = 0;
        end else begin
            room = (m_q.size() < 4);
            acked = m_en & out_ack;
            grant = m_busy ? (m_pend & ~m_en & out_rdy) : 4'b0000;
            if (m_busy) begin
                m_pend = m_pend & ~acked;
                m_en = (m_en & ~acked) | grant;
                if (m_pend == 4'b0000) begin
                    gone = m_q.pop_front();
                    m_busy = 1'b0;
                    m_sent++;
                end
            end else if (m_q.size() != 0) begin
                if (m_q[0].dest == 4'b0000) begin
                    gone = m_q.pop_front();
                    m_drop++;
                end else begin
                    m_busy = 1'b1;
                    m_pend = m_q[0].dest;
                end
            end
            if (adder_ack) begin
                if (room) m_q.push_back('{adder_outputs, dest_info});
                else begin
                    m_ovf = 1'b1;
                    m_drop++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_out_en", out_en, m_en);
            chk("model_cap_rdy", cap_rdy, m_q.size() < 4);
            chk("model_out_data", out_data, (m_q.size() != 0) ? m_q[0].data : '0);
            chk("model_ovf", ovf, m_ovf);
`ifdef ROUTER_STATS_EN
            chk("model_sent_cnt", sent_cnt, (m_sent > 65535) ? 16'hFFFF : 16'(m_sent));
            chk("model_drop_cnt", drop_cnt, (m_drop > 65535) ? 16'hFFFF : 16'(m_drop));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [VW-1:0] data, input logic [3:0] dest);
        adder_outputs = data;
        dest_info = dest;
        adder_ack = 1'b1;
        step();
        adder_ack = 1'b0;
        dest_info = 4'b0000;
    endtask

    task automatic wait_dlv(input int n, input string name);
        int k;
        k = 0;
        while (dlog.size() < n && k < 80) begin
            step();
            k++;
        end
        chk(name, dlog.size(), n);
    endtask

    initial begin
        int base;
        int firsts[4];

        // Reset state
        repeat (3) step();
        chk_on = 1'b1;
        chk("reset_out_en", out_en, 4'b0000);
        chk("reset_cap_rdy", cap_rdy, 1'b1);
        chk("reset_out_data", out_data, '0);
        chk("reset_ovf", ovf, 1'b0);
        reset = 1'b0;
        step();

        // Discard: dest==0 is popped without any enable
        out_rdy = 4'hF;
        strobe(mkvec(5), 4'b0000);
        chk("discard_head_visible", out_data, mkvec(5));
        step();
        chk("discard_popped", out_data, '0);
        repeat (3) begin
            step();
            chk("discard_no_en", out_en, 4'b0000);
        end
`ifdef ROUTER_STATS_EN
        chk("discard_drop_cnt", drop_cnt, 16'd1);
        chk("discard_sent_cnt", sent_cnt, 16'd0);
`endif

        // Single destination, ack one cycle after en
        dly[0] = 1;
        strobe(mkvec(1), 4'b0001);
        step();
        step();
        chk("single_en_t2", out_en, 4'b0001);
        chk("single_data", out_data, 64'h0001_0002_0003_0004);
        step();
        chk("single_en_hold", out_en, 4'b0001);
        step();
        chk("single_en_clear", out_en, 4'b0000);
        chk("single_empty", out_data, '0);
        chk("single_cap_rdy", cap_rdy, 1'b1);
        dly[0] = 0;

        // Multicast skew: E acks at +1, W rdy late, spurious W ack before en
        out_rdy = 4'b0010;
        dly[1] = 1;
        strobe(mkvec(16'hA0), 4'b1010);
        step();
        step();
        chk("mc_en_e_only", out_en, 4'b0010);
        spur_ack = 4'b1000;
        step();
        spur_ack = 4'b0000;
        chk("mc_en_e_hold", out_en, 4'b0010);
        step();
        chk("mc_e_cleared", out_en, 4'b0000);
        chk("mc_data_held", out_data, mkvec(16'hA0));
        step();
        chk("mc_w_waits", out_en, 4'b0000);
        out_rdy = 4'b1010;
        step();
        chk("mc_w_rises", out_en, 4'b1000);
        step();
        chk("mc_w_cleared", out_en, 4'b0000);
        chk("mc_popped", out_data, '0);
        dly[1] = 0;

        // Fill: five strobes with no rdy, then release in push order
        out_rdy = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            strobe(mkvec(16 * (i + 1)), 4'b0001);
            if (i == 2) chk("fill_cap_rdy_3", cap_rdy, 1'b1);
            if (i == 3) chk("fill_cap_rdy_4", cap_rdy, 1'b0);
        end
        chk("fill_ovf", ovf, 1'b1);
        chk("fill_still_full", cap_rdy, 1'b0);
        base = dlog.size();
        out_rdy = 4'hF;
        wait_dlv(base + 4, "fill_delivered");
        for (int k = 0; k < 4 && base + k < dlog.size(); k++) begin
            chk("fill_order_data", dlog[base + k].data, mkvec(16 * (k + 1)));
            chk("fill_order_dir", dlog[base + k].dir, 0);
        end
`ifdef ROUTER_STATS_EN
        chk("fill_sent_cnt", sent_cnt, 16'd6);
        chk("fill_drop_cnt", drop_cnt, 16'd2);
`endif

        // Reset in the middle of a send
        step();
        dly[2] = 20;
        strobe(mkvec(16'h40), 4'b0100);
        step();
        step();
        chk("rst_mid_en", out_en, 4'b0100);
        reset = 1'b1;
        step();
        chk("rst_mid_out_en", out_en, 4'b0000);
        chk("rst_mid_cap_rdy", cap_rdy, 1'b1);
        chk("rst_mid_ovf", ovf, 1'b0);
        chk("rst_mid_data", out_data, '0);
`ifdef ROUTER_STATS_EN
        chk("rst_mid_sent_cnt", sent_cnt, 16'd0);
`endif
        reset = 1'b0;
        dly[2] = 0;
        step();

        // Back-to-back strobes with immediate acks
        base = dlog.size();
        strobe(mkvec(16'h100), 4'b0001);
        strobe(mkvec(16'h200), 4'b0110);
        strobe(mkvec(16'h300), 4'b1111);
        strobe(mkvec(16'h400), 4'b1000);
        wait_dlv(base + 8, "b2b_delivered");
        if (dlog.size() >= base + 8) begin
            chk("b2b_v0", dlog[base].data, mkvec(16'h100));
            chk("b2b_v1_dir", dlog[base + 2].dir, 2);
            chk("b2b_v1", dlog[base + 2].data, mkvec(16'h200));
            chk("b2b_v2_dir", dlog[base + 6].dir, 3);
            chk("b2b_v2", dlog[base + 6].data, mkvec(16'h300));
            chk("b2b_v3_dir", dlog[base + 7].dir, 3);
            chk("b2b_v3", dlog[base + 7].data, mkvec(16'h400));
            firsts[0] = dlog[base].c;
            firsts[1] = dlog[base + 1].c;
            firsts[2] = dlog[base + 3].c;
            firsts[3] = dlog[base + 7].c;
            for (int k = 1; k < 4; k++) begin
                chk("b2b_gap", firsts[k] - firsts[k - 1], 3);
            end
            chk("b2b_v2_same_cycle", dlog[base + 6].c, dlog[base + 3].c);
        end
        repeat (3) step();
        chk("b2b_empty", out_data, '0);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
